// File: rtl/mac_pkg.sv
// Shared types and width/bound helpers for the FIR multiply-accumulate engine.
package mac_pkg;

    typedef enum logic {
        VACIO      = 1'b0,
        ACUMULANDO = 1'b1
    } estado_t;

    function automatic int acc_w(input int n, input int guard);
        return 2 * n + guard;
    endfunction

    function automatic int cnt_w(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

    function automatic longint sat_max(input int n);
        return (longint'(1) << (n - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int n);
        return -(longint'(1) << (n - 1));
    endfunction

endpackage

// File: rtl/mac_acumulador_fir_if.sv
// Pair stream in, frame result out; both directions use valid/ready.
interface mac_acumulador_fir_if #(parameter int N = 25) ();

    logic                in_valid;
    logic                in_ready;
    logic                in_last;
    logic signed [N-1:0] multiplicando;
    logic signed [N-1:0] constante;
    logic                out_valid;
    logic                out_ready;
    logic signed [N-1:0] suma_out;
    logic                overflow;

    modport master (
        output in_valid, in_last, multiplicando, constante, out_ready,
        input  in_ready, out_valid, suma_out, overflow
    );

    modport slave (
        input  in_valid, in_last, multiplicando, constante, out_ready,
        output in_ready, out_valid, suma_out, overflow
    );

endinterface

// File: rtl/mac_acumulador_fir_mult_registrado.sv
// Product stage: signed N x N multiply into a 2N-bit register, held when en=0.
module mult_registrado #(
    parameter int N = 25
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  flush,
    input  logic signed [N-1:0]   a,
    input  logic signed [N-1:0]   b,
    output logic signed [2*N-1:0] p
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      p <= '0;
        else if (flush)  p <= '0;
        else if (en)     p <= (2*N)'(a) * (2*N)'(b);
    end

endmodule

// File: rtl/mac_acumulador_fir.sv
// Pipelined MAC: S1 registered product, S2 accumulate/scale into the output register.
// Define MAC_SATURACION_EN to clamp out-of-range results instead of wrapping.
module mac_acumulador_fir
    import mac_pkg::*;
#(
    parameter int N     = 25,
    parameter int FRAC  = 10,
    parameter int TAPS  = 16,
    parameter int GUARD = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    input logic                 clr,
    mac_acumulador_fir_if.slave bus
);

    localparam int ACC_W = acc_w(N, GUARD);
    localparam int CNT_W = cnt_w(TAPS);

    logic                    rdy_q, stall, accept, last_in, fire, load;
    logic                    p_valid, last_f;
    logic                    out_valid_q, overflow_q, ovf_c;
    logic [CNT_W-1:0]        count;
    logic signed [2*N-1:0]   prod;
    logic signed [ACC_W-1:0] acc_q, acc_d, acc_next, prod_ext;
    logic signed [N-1:0]     suma_q, sat_val;
    estado_t                 state_q, state_d;

    assign stall        = out_valid_q & ~bus.out_ready;
    assign bus.in_ready = rdy_q & ~stall;
    assign accept       = bus.in_valid & bus.in_ready & ~clr;
    assign bus.out_valid = out_valid_q;
    assign bus.suma_out  = suma_q;
    assign bus.overflow  = overflow_q;

    // Taps are counted at acceptance so back-to-back pairs see an up-to-date count.
    assign last_in = bus.in_last | (count == CNT_W'(TAPS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_q <= 1'b0;
        else        rdy_q <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      count <= '0;
        else if (clr)    count <= '0;
        else if (accept) count <= last_in ? '0 : count + CNT_W'(1);
    end

    mult_registrado #(.N(N)) u_mult (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept),
        .flush (clr),
        .a     (bus.multiplicando),
        .b     (bus.constante),
        .p     (prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid <= 1'b0;
            last_f  <= 1'b0;
        end else if (clr) begin
            p_valid <= 1'b0;
            last_f  <= 1'b0;
        end else if (!stall) begin
            p_valid <= accept;
            last_f  <= last_in;
        end
    end

    assign fire     = p_valid & ~stall;
    assign prod_ext = ACC_W'(prod);
    assign acc_next = (state_q == VACIO) ? prod_ext : acc_q + prod_ext;

`ifdef MAC_SATURACION_EN
    localparam logic signed [ACC_W-1:0] RES_MAX = ACC_W'(sat_max(N));
    localparam logic signed [ACC_W-1:0] RES_MIN = ACC_W'(sat_min(N));
    logic signed [ACC_W-1:0] res;

    always_comb begin
        res     = acc_next >>> FRAC;
        sat_val = res[N-1:0];
        ovf_c   = 1'b0;
        if (res > RES_MAX) begin
            sat_val = RES_MAX[N-1:0];
            ovf_c   = 1'b1;
        end else if (res < RES_MIN) begin
            sat_val = RES_MIN[N-1:0];
            ovf_c   = 1'b1;
        end
    end
`else
    assign sat_val = N'(acc_next >>> FRAC);
    assign ovf_c   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        load    = 1'b0;
        if (fire) begin
            if (last_f) begin
                state_d = VACIO;
                acc_d   = '0;
                load    = 1'b1;
            end else begin
                state_d = ACUMULANDO;
                acc_d   = acc_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= VACIO;
            acc_q   <= '0;
        end else if (clr) begin
            state_q <= VACIO;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
        end
    end

    // A fresh result may replace one being consumed in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            suma_q      <= '0;
            overflow_q  <= 1'b0;
        end else if (clr) begin
            out_valid_q <= 1'b0;
            suma_q      <= '0;
            overflow_q  <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            suma_q      <= sat_val;
            overflow_q  <= ovf_c;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_acumulador_fir.sv
// Directed scoreboard bench for mac_acumulador_fir (N=8, FRAC=4, TAPS=4, GUARD=2).
module tb_mac_acumulador_fir;

    typedef struct packed {
        logic [7:0] d;
        logic       o;
    } exp_t;

    logic clk, rst_n, clr;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    mac_acumulador_fir_if #(.N(8)) bus ();

    mac_acumulador_fir #(.N(8), .FRAC(4), .TAPS(4), .GUARD(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_res(input logic [7:0] d, input logic o);
        exp_t e;
        e.d = d;
        e.o = o;
        q.push_back(e);
    endtask

    task automatic send(input logic [7:0] m, input logic [7:0] c, input logic l);
        int t;
        t = 0;
        bus.in_valid      = 1'b1;
        bus.multiplicando = m;
        bus.constante     = c;
        bus.in_last       = l;
        @(negedge clk);
        while (!bus.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck at 0 for pair %h*%h", m, c);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results still pending, expected 0", q.size());
        end
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {7'b0, bus.out_valid}, 8'h00);
        chk("rst_suma_out",  bus.suma_out,          8'h00);
        chk("rst_overflow",  {7'b0, bus.overflow},  8'h00);
        chk("rst_in_ready",  {7'b0, bus.in_ready},  8'h00);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every consumed result against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && !bus.out_ready) begin
                checks++;
                if (bus.in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_in_ready: got %b expected 0", bus.in_ready);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got %h with nothing expected", bus.suma_out);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (bus.suma_out !== e.d || bus.overflow !== e.o) begin
                        errors++;
                        $display("FAIL result: got %h ovf %b expected %h ovf %b",
                                 bus.suma_out, bus.overflow, e.d, e.o);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_last       = 1'b0;
        bus.multiplicando = '0;
        bus.constante     = '0;
        bus.out_ready     = 1'b1;
        #1;
        chk("init_out_valid", {7'b0, bus.out_valid}, 8'h00);
        chk("init_suma_out",  bus.suma_out,          8'h00);
        chk("init_overflow",  {7'b0, bus.overflow},  8'h00);
        chk("init_in_ready",  {7'b0, bus.in_ready},  8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: 1.5 * 2.0
        expect_res(8'h30, 1'b0);
        send(8'h18, 8'h20, 1'b1);
        drain();

        // 2: -0.5 + 1.0
        expect_res(8'h08, 1'b0);
        send(8'hF0, 8'h08, 1'b0);
        send(8'h10, 8'h10, 1'b1);
        drain();

        // 3: 7.0 * 7.0 = 49.0 is out of range
`ifdef MAC_SATURACION_EN
        expect_res(8'h7F, 1'b1);
`else
        expect_res(8'h10, 1'b0);
`endif
        send(8'h70, 8'h70, 1'b1);
        drain();

        // 4: frame force-closed at the 4th pair; second frame closes by count too
        expect_res(8'h40, 1'b0);
        expect_res(8'h10, 1'b0);
        repeat (5) send(8'h10, 8'h10, 1'b0);
        repeat (3) send(8'h00, 8'h00, 1'b0);
        drain();

        // 5: streaming single-pair frames under backpressure
        for (int i = 1; i <= 8; i++) expect_res(8'(i), 1'b0);
        fork
            begin
                for (int i = 1; i <= 8; i++) send(8'h10, 8'(i), 1'b1);
            end
            begin
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();

        // 6a: clr mid-frame, and a pair presented with clr is ignored
        send(8'h10, 8'h10, 1'b0);
        send(8'h10, 8'h10, 1'b0);
        clr = 1'b1;
        bus.in_valid = 1'b1;
        bus.multiplicando = 8'h70;
        bus.constante = 8'h70;
        bus.in_last = 1'b0;
        @(posedge clk);
        #1;
        clr = 1'b0;
        bus.in_valid = 1'b0;
        expect_res(8'h10, 1'b0);
        send(8'h10, 8'h10, 1'b1);
        drain();

        // 6b: async reset clears a held result
        bus.out_ready = 1'b0;
        send(8'h18, 8'h20, 1'b1);
        repeat (3) @(negedge clk);
        chk("held_valid", {7'b0, bus.out_valid}, 8'h01);
        chk("held_suma",  bus.suma_out,          8'h30);
        pulse_reset();
        bus.out_ready = 1'b1;

        // 6c: async reset mid-frame discards the partial sum
        send(8'h10, 8'h10, 1'b0);
        send(8'h10, 8'h10, 1'b0);
        pulse_reset();
        expect_res(8'h10, 1'b0);
        send(8'h10, 8'h10, 1'b1);
        drain();

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
